// File: rtl/sensor_scan_if.sv
// Sensor-matrix scanner bus.
//   scan_en    : run scanning while high
//   row_in     : raw row sense lines for the driven column (1 = car present)
//   col_n      : active-low one-hot column drive, 4'b1111 when idle
//   occ        : debounced occupancy map, bit 4*col+row
//   free_cnt   : 16 minus popcount(occ), one cycle behind occ
//   frame_done : one-cycle pulse at the end of each full 4-column frame
//   changed    : coincident with frame_done when any occ bit flipped in that frame
interface sensor_scan_if;
  logic        scan_en;
  logic [3:0]  row_in;
  logic [3:0]  col_n;
  logic [15:0] occ;
  logic [4:0]  free_cnt;
  logic        frame_done;
  logic        changed;

  modport master (
    output scan_en, row_in,
    input  col_n, occ, free_cnt, frame_done, changed
  );

  modport slave (
    input  scan_en, row_in,
    output col_n, occ, free_cnt, frame_done, changed
  );
endinterface

// File: rtl/sensor_scan.sv
// Multiplexed parking-spot sensor scanner with per-spot frame debounce.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sensor_scan_if.slave (scan_en/row_in in; col_n/occ/free_cnt/frame_done/changed out)
// Parameters:
//   SETTLE_CYC : cycles a column is driven before its rows are sampled (>=1)
//   DEB_CNT    : consecutive disagreeing frames needed to accept a change (>=1)
module sensor_scan #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned DEB_CNT    = 3
) (
  input  logic          clk,
  input  logic          rst,
  sensor_scan_if.slave  bus
);

  localparam int unsigned DEB_W = $clog2(DEB_CNT + 1);
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_col;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_col_n;
  logic [15:0]      r_occ;
  logic [4:0]       r_free;
  logic             r_fd;
  logic             r_chg;
  logic             r_fe_pend;
  logic             r_chg_pend;
  logic             r_sticky;
  logic [DEB_W-1:0] r_deb [16];

  logic [1:0]       w_state_nxt;
  logic [1:0]       w_col_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      w_occ_nxt;
  logic [DEB_W-1:0] w_deb_nxt [16];
  logic             w_flip;
  logic             w_frame_end;
  logic [4:0]       w_pop;

  // Next-state: settle counter, column index and frame sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.scan_en) begin
          w_state_nxt = S_SETTLE;
          w_col_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        w_cnt_nxt = '0;
        w_col_nxt = r_col + 2'd1;
        // A frame is never cut short by scan_en; it is only checked at frame end
        if ((r_col == 2'd3) && !bus.scan_en) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SETTLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_col_nxt   = 2'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Per-spot debounce for the four rows of the sampled column
  always_comb begin
    w_occ_nxt = r_occ;
    w_deb_nxt = r_deb;
    w_flip    = 1'b0;
    if (r_state == S_SAMPLE) begin
      for (int r = 0; r < 4; r++) begin
        if (bus.row_in[r] == r_occ[{r_col, 2'(r)}]) begin
          w_deb_nxt[{r_col, 2'(r)}] = '0;
        end else if (r_deb[{r_col, 2'(r)}] + DEB_W'(1) == DEB_W'(DEB_CNT)) begin
          w_occ_nxt[{r_col, 2'(r)}] = ~r_occ[{r_col, 2'(r)}];
          w_deb_nxt[{r_col, 2'(r)}] = '0;
          w_flip                    = 1'b1;
        end else begin
          w_deb_nxt[{r_col, 2'(r)}] = r_deb[{r_col, 2'(r)}] + DEB_W'(1);
        end
      end
    end
  end

  // Occupied-spot count
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 16; i++) begin
      w_pop = w_pop + 5'(r_occ[i]);
    end
  end

  assign w_frame_end = (r_state == S_SAMPLE) && (r_col == 2'd3);

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col      <= 2'd0;
      r_cnt      <= '0;
      r_col_n    <= 4'b1111;
      r_occ      <= '0;
      r_free     <= 5'd16;
      r_fd       <= 1'b0;
      r_chg      <= 1'b0;
      r_fe_pend  <= 1'b0;
      r_chg_pend <= 1'b0;
      r_sticky   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_deb[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_cnt   <= w_cnt_nxt;
      // Column drive follows the next state so it is valid for the whole SETTLE window
      r_col_n <= (w_state_nxt == S_IDLE) ? 4'b1111 : ~(4'b0001 << w_col_nxt);
      r_occ   <= w_occ_nxt;
      r_deb   <= w_deb_nxt;
      r_free  <= 5'd16 - w_pop;
      // Frame pulse is delayed one edge so free_cnt already reflects the final occ
      if (w_frame_end) begin
        r_fe_pend  <= 1'b1;
        r_chg_pend <= r_sticky | w_flip;
        r_sticky   <= 1'b0;
      end else begin
        r_fe_pend <= 1'b0;
        if (w_flip) begin
          r_sticky <= 1'b1;
        end
      end
      r_fd  <= r_fe_pend;
      r_chg <= r_fe_pend & r_chg_pend;
    end
  end

  assign bus.col_n      = r_col_n;
  assign bus.occ        = r_occ;
  assign bus.free_cnt   = r_free;
  assign bus.frame_done = r_fd;
  assign bus.changed    = r_chg;

endmodule

// File: tb/tb_sensor_scan.sv
// Directed self-checking bench for sensor_scan at default parameters.
// Cycle k is the interval after edge E(k-1), E0 being the edge that first samples scan_en high.
module tb_sensor_scan;

  logic        clk;
  logic        rst;
  logic [15:0] pat;
  int          cyc;
  int          checks;
  int          errors;

  sensor_scan_if bus ();

  sensor_scan dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor matrix model: rows of the driven column reflect the spot pattern
  always_comb begin
    case (bus.col_n)
      4'b1110: bus.row_in = pat[3:0];
      4'b1101: bus.row_in = pat[7:4];
      4'b1011: bus.row_in = pat[11:8];
      4'b0111: bus.row_in = pat[15:12];
      default: bus.row_in = 4'b0000;
    endcase
  end

  typedef struct {
    int         lo;
    int         hi;
    logic [3:0] col_n;
    logic       fd;
  } seg_t;

  seg_t segs [13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.scan_en = 1'b0;
    pat         = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start();
    bus.scan_en = 1'b1;
    cyc         = 0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    rst         = 1'b1;
    bus.scan_en = 1'b0;
    pat         = '0;

    segs[0]  = '{1, 5, 4'b1110, 1'b0};
    segs[1]  = '{6, 10, 4'b1101, 1'b0};
    segs[2]  = '{11, 15, 4'b1011, 1'b0};
    segs[3]  = '{16, 20, 4'b0111, 1'b0};
    segs[4]  = '{21, 21, 4'b1110, 1'b0};
    segs[5]  = '{22, 22, 4'b1110, 1'b1};
    segs[6]  = '{23, 25, 4'b1110, 1'b0};
    segs[7]  = '{26, 30, 4'b1101, 1'b0};
    segs[8]  = '{31, 35, 4'b1011, 1'b0};
    segs[9]  = '{36, 40, 4'b0111, 1'b0};
    segs[10] = '{41, 41, 4'b1110, 1'b0};
    segs[11] = '{42, 42, 4'b1110, 1'b1};
    segs[12] = '{43, 45, 4'b1110, 1'b0};

    // Reset held for two edges
    @(negedge clk);
    @(negedge clk);
    chk("rst_col_n", 32'(bus.col_n), 32'hF);
    chk("rst_occ", 32'(bus.occ), 32'h0);
    chk("rst_free", 32'(bus.free_cnt), 32'd16);
    chk("rst_fd", 32'(bus.frame_done), 32'd0);
    chk("rst_chg", 32'(bus.changed), 32'd0);
    rst = 1'b0;

    // Continuous scan sequence checked against the segment table
    start();
    for (int k = 1; k <= 45; k++) begin
      adv();
      for (int s = 0; s < 13; s++) begin
        if (k >= segs[s].lo && k <= segs[s].hi) begin
          chk("seq_col_n", 32'(bus.col_n), 32'(segs[s].col_n));
          chk("seq_fd", 32'(bus.frame_done), 32'(segs[s].fd));
        end
      end
    end

    // Debounce accept on spot 5
    do_reset();
    pat = 16'h0020;
    start();
    for (int k = 1; k <= 65; k++) begin
      adv();
      chk("acc_chg", 32'(bus.changed), 32'(k == 62));
      chk("acc_fd", 32'(bus.frame_done), 32'(k == 22 || k == 42 || k == 62));
      if (k == 11 || k == 31 || k == 50) chk("acc_occ_hold", 32'(bus.occ), 32'h0);
      if (k == 51) chk("acc_occ_set", 32'(bus.occ), 32'h0020);
      if (k == 51) chk("acc_free_lag", 32'(bus.free_cnt), 32'd16);
      if (k == 52) chk("acc_free", 32'(bus.free_cnt), 32'd15);
    end

    // Glitch reject: two frames high, one low, then a fresh three-frame run
    do_reset();
    pat = 16'h0020;
    start();
    for (int k = 1; k <= 125; k++) begin
      adv();
      if (k == 35) pat = 16'h0000;
      if (k == 55) pat = 16'h0020;
      chk("gl_chg", 32'(bus.changed), 32'(k == 122));
      if (k == 51 || k == 71 || k == 91 || k == 110) chk("gl_occ_hold", 32'(bus.occ), 32'h0);
      if (k == 111) chk("gl_occ_set", 32'(bus.occ), 32'h0020);
    end

    // Full then empty
    do_reset();
    pat = 16'hFFFF;
    start();
    for (int k = 1; k <= 125; k++) begin
      adv();
      if (k == 62) pat = 16'h0000;
      chk("fe_chg", 32'(bus.changed), 32'(k == 62 || k == 122));
      if (k == 41) chk("fe_occ_hold", 32'(bus.occ), 32'h0);
      if (k == 56) chk("fe_occ_part", 32'(bus.occ), 32'h0FFF);
      if (k == 57) chk("fe_free_part", 32'(bus.free_cnt), 32'd4);
      if (k == 61) chk("fe_occ_full", 32'(bus.occ), 32'hFFFF);
      if (k == 62) chk("fe_free_0", 32'(bus.free_cnt), 32'd0);
      if (k == 101) chk("fe_occ_hold2", 32'(bus.occ), 32'hFFFF);
      if (k == 116) chk("fe_occ_part2", 32'(bus.occ), 32'hF000);
      if (k == 121) chk("fe_occ_empty", 32'(bus.occ), 32'h0);
      if (k == 122) chk("fe_free_16", 32'(bus.free_cnt), 32'd16);
    end

    // scan_en dropped during column 1: frame completes, then idle
    do_reset();
    start();
    for (int k = 1; k <= 45; k++) begin
      adv();
      if (k == 7) bus.scan_en = 1'b0;
      chk("en_fd", 32'(bus.frame_done), 32'(k == 22));
      if (k == 8) chk("en_col1", 32'(bus.col_n), 32'hD);
      if (k == 13) chk("en_col2", 32'(bus.col_n), 32'hB);
      if (k == 20) chk("en_col3", 32'(bus.col_n), 32'h7);
      if (k == 21 || k == 30 || k == 45) chk("en_idle", 32'(bus.col_n), 32'hF);
    end

    // Reset during column 2 of frame 4 abandons the frame
    do_reset();
    pat = 16'hFFFF;
    start();
    for (int k = 1; k <= 95; k++) begin
      adv();
      if (k == 71) chk("mr_occ_pre", 32'(bus.occ), 32'hFFFF);
      if (k == 72) chk("mr_col_pre", 32'(bus.col_n), 32'hB);
      if (k == 72) rst = 1'b1;
      if (k == 73) begin
        chk("mr_col_n", 32'(bus.col_n), 32'hF);
        chk("mr_occ", 32'(bus.occ), 32'h0);
        chk("mr_free", 32'(bus.free_cnt), 32'd16);
      end
      if (k == 74) begin
        rst         = 1'b0;
        bus.scan_en = 1'b0;
      end
      if (k >= 73) begin
        chk("mr_fd", 32'(bus.frame_done), 32'd0);
        chk("mr_chg", 32'(bus.changed), 32'd0);
      end
      if (k == 95) chk("mr_idle", 32'(bus.col_n), 32'hF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_scan.md
# sensor_scan

Multiplexed scanner for the parking-spot sensor matrix: drives four column-select lines one at a time, samples four row lines per column, debounces each of the 16 spots, and publishes a stable occupancy map and free-spot count. It is the input-side counterpart of the multiplexed display scan. Its `free_cnt` and `occ` outputs feed the vacancy logic and the display path.

## Interface

Parameters:
- `SETTLE_CYC`, default 4: cycles a column is driven before its rows are sampled (≥1).
- `DEB_CNT`, default 3: consecutive disagreeing frames required to accept a spot change (≥1).

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `scan_en`, in, 1: run scanning while high.
- `row_in`, in, 4: raw row sense lines, 1 = car present, for the currently driven column.
- `col_n`, out, 4: column drive, active-low, one-hot. `4'b1111` when idle.
- `occ`, out, 16: debounced occupancy; bit `4*col+row`.
- `free_cnt`, out, 5: 16 minus popcount(`occ`).
- `frame_done`, out, 1: one-cycle pulse; a full 4-column frame is complete and `free_cnt` is consistent with `occ`.
- `changed`, out, 1: one-cycle pulse coincident with `frame_done` if any `occ` bit flipped during that frame.

## Operation

- State machine states: IDLE, SETTLE, SAMPLE. There is a 2-bit column index `col` that wraps from 3 to 0.
- IDLE:
  - `col_n=1111`.
  - When `scan_en` is sampled high, go to SETTLE with `col=0`.
- SETTLE:
  - `col_n = ~(1<<col)`.
  - Stays for exactly `SETTLE_CYC` cycles, then goes to SAMPLE.
- SAMPLE (1 cycle):
  - `col_n` is still driven.
  - For each row r, spot s=4*col+r:
    - if `row_in[r]==occ[s]`: clear `deb[s]`.
    - else: `deb[s]+1`. On reaching `DEB_CNT`, invert `occ[s]` and clear `deb[s]`.
- After SAMPLE with `col<3`: `col+1`, go to SETTLE.
- After SAMPLE with `col==3`:
  - `col` wraps to 0 and the frame-end pulse is scheduled.
  - If `scan_en` is high, go to SETTLE; else go to IDLE.
- `scan_en` deasserted mid-frame does not abort; the current frame completes, then the block enters IDLE.
- Debounce counters are per spot, width clog2(`DEB_CNT`+1). They are counted in frames, never in cycles. Any agreeing sample clears the counter; there is no partial decay.
- `free_cnt` is registered and recomputed from `occ` every cycle, so it lags `occ` by one cycle. Range is 0..16 and it never wraps.
- A sticky frame-change flag is set on any `occ` flip. It is copied to `changed` at frame end and then cleared.

## Timing

- Reset values:
  - `col_n=1111`, `occ=0`, `free_cnt=16`, `frame_done=0`, `changed=0`.
  - All `deb` counters 0, state IDLE, `col=0`, sticky flag 0.
- `rst` has priority over everything. Asserted mid-frame, the frame is abandoned and no `frame_done` is issued; outputs hold reset values from the next edge.
- Column period: `SETTLE_CYC`+1 cycles. Frame period: 4·(`SETTLE_CYC`+1) cycles (20 at defaults).
- Frame timeline at defaults, relative to edge E0 where `scan_en` is first sampled high:
  - Column c is in SETTLE during cycles 1+5c..4+5c and in SAMPLE during cycle 5+5c.
  - `occ` updates on the edge ending each SAMPLE cycle.
  - `free_cnt` updates one edge later.
  - `frame_done` and `changed` are high during cycle 22.
- Continuous scan: frame k+1's column-0 SETTLE begins in cycle 21, with no gap. Frame pulses occur every 20 cycles.
- A spot change is accepted at the column-c SAMPLE of the `DEB_CNT`-th consecutive disagreeing frame.

## Test plan

- **Reset:** assert `rst` 2 cycles → `col_n=1111`, `occ=0`, `free_cnt=16`, `frame_done=0`.
- **Scan sequence** (defaults), `scan_en=1` held:
  - `col_n` = 1110 during cycles 1–5, 1101 during 6–10, 1011 during 11–15, 0111 during 16–20.
  - `frame_done` high only in cycle 22, then again in cycle 42.
- **Debounce accept:** `row_in[1]=1` whenever col 1 is driven (spot 5), `DEB_CNT=3`:
  - `occ[5]` stays 0 after frames 1–2 and becomes 1 at the frame-3 col-1 SAMPLE.
  - `free_cnt` is 15 next cycle; `changed=1` only with the frame-3 `frame_done`.
- **Glitch reject:** spot 5 high for 2 frames then low → `occ` stays 0, `changed` never asserts, and a later 3-frame assertion is still needed.
- **Full/empty:**
  - All rows high for 3 frames → `occ=16'hFFFF`, `free_cnt=0`.
  - All rows low for 3 frames → `free_cnt=16`, `changed` pulses once on each transition frame.
- **Interruptions:**
  - `scan_en` dropped during col 1 → remaining columns scanned, `frame_done` pulses, `col_n=1111` afterwards.
  - `rst` during col 2 → reset values next edge, no `frame_done`.
